apb_completer_regfile: RTL and testbench
========================================

Name: apb_completer_regfile

Overview:
- APB completer (slave) with a wait-state-programmable register file. It is the responder end of the APB bus that the transfer/read_write master-side interface drives through the bridge.
- Decodes the setup and access phases, inserts a fixed number of wait states, commits writes and returns read data.
- Flags out-of-range addresses with pslverr.
- Two instances (slave 0 and slave 1) sit behind the bridge's address decode.

Parameters:
- AW, 8, address width (matches `AW)
- DW, 8, data width (matches `DW)
- DEPTH, 64, number of DW-bit registers; valid addresses 0..DEPTH-1
- WAIT_CYCLES, 1, extra wait states beyond the inherent one; 0..15

Ports:
- pclk  input  1  bus clock; all logic on rising edge
- presetn  input  1  reset, synchronous, active-low
- psel  input  1  completer select
- penable  input  1  access-phase strobe
- pwrite  input  1  1=write, 0=read
- paddr  input  AW  transfer address
- pwdata  input  DW  write data
- prdata  output  DW  read data, valid only while pready=1 on a read
- pready  output  1  transfer complete strobe
- pslverr  output  1  error response, valid only while pready=1

Behaviour:
- Reset: one clock; reset is synchronous and active-low (pclk, presetn).
  - Sampled presetn=0 at a pclk edge: state=IDLE, pready=0, pslverr=0, prdata=0, wait counter=0, all DEPTH registers=0.
  - Reset mid-transfer aborts the transfer with no write and no pready.
- All outputs are registered.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - psel=1 and penable=0 (setup phase): capture paddr, pwrite, pwdata; load cnt=WAIT_CYCLES; go ACCESS.
  - Any other input combination: stay in IDLE.
  - psel=1 with penable=1 while in IDLE is a protocol error and is ignored; no response.
- ACCESS:
  - psel=0: abort to IDLE; no write, pready stays 0.
  - psel=1, penable=1, cnt!=0: decrement cnt; pready stays 0.
  - psel=1, penable=1, cnt==0: complete the transfer at this edge and go DONE.
    - Set pready<=1.
    - In range (addr<DEPTH), write: mem[addr]<=captured wdata; pslverr<=0.
    - In range, read: prdata<=mem[addr]; pslverr<=0.
    - addr>=DEPTH: pslverr<=1, prdata<=0, no write.
- Latency:
  - pready-low access cycles = WAIT_CYCLES+1.
  - Total transfer = 1 setup cycle + WAIT_CYCLES+2 access cycles.
  - Default: 4 cycles from setup to completion edge.
- DONE (pready=1 for exactly one cycle):
  - Next edge: pready<=0, pslverr<=0, prdata<=0.
  - If psel=1 and penable=0 (back-to-back setup): capture, load cnt, go ACCESS.
  - Otherwise: go IDLE.
- paddr, pwrite and pwdata changes during the access phase are ignored; the captured setup values are used.
- Read-after-write to the same address in consecutive transfers returns the new data.

Test Plan:
- Reset: presetn=0 for 2 cycles with psel=1, penable=0 → pready=0, pslverr=0, prdata=0; a read of addr 0x05 afterwards returns 0x00.
- Write then read, WAIT_CYCLES=1:
  - Write 0xA5 to 0x10 → pready high in 3rd access cycle, pslverr=0.
  - Read 0x10 → prdata=0xA5 while pready=1, then prdata=0x00 on the next cycle.
- Out of range: write 0x3C to 0x40 (DEPTH=64) → pready=1 with pslverr=1. A following read of 0x00 returns its prior value (write dropped). A read of 0xFF → pslverr=1, prdata=0x00.
- Back-to-back transfers:
  - Setup of write 0x22→0x01 immediately in the DONE cycle of write 0x11→0x00; no idle cycle between them.
  - Both complete; reads return 0x11 and 0x22.
- Abort and reset:
  - Drop psel after 1 access cycle of write 0x77→0x02 → no pready; mem[0x02] unchanged.
  - Assert presetn=0 during a read's wait cycle → pready never rises, and all outputs are 0 at the next edge.
- Wait sweep: WAIT_CYCLES=0 and 3 → pready-low access cycles measured as exactly 1 and 4.

Source files
------------

// File: rtl/apb_completer_regfile_if.sv
// APB bus bundle between a requester and the register-file completer.
// Clock and reset stay outside so several completers can share one bus clock.
interface apb_completer_regfile_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_completer_regfile.sv
// APB completer with a DEPTH-entry register file and WAIT_CYCLES extra wait states.
// Setup values are captured once; all bus outputs come straight from flops.
module apb_completer_regfile #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic pclk,
    input  logic presetn,
    apb_completer_regfile_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] prdata_q;
    logic          pready_q;
    logic          pslverr_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic          in_range;
    logic [IW-1:0] idx;
    logic          setup;

    assign in_range = (32'(addr_q) < DEPTH);
    assign idx      = addr_q[IW-1:0];
    assign setup    = bus.psel && !bus.penable;

    always_ff @(posedge pclk) begin
        // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            // NOTE: the register file is cleared on reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        addr_q  <= bus.paddr;
                        write_q <= bus.pwrite;
                        wdata_q <= bus.pwdata;
                        cnt_q   <= WAIT_LD;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!bus.psel) begin
                        state_q <= IDLE;
                    end else if (bus.penable) begin
                        if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            pready_q <= 1'b1;
                            state_q  <= DONE;
                            if (!in_range) begin
                                pslverr_q <= 1'b1;
                                prdata_q  <= '0;
                            end else if (write_q) begin
                                mem_q[idx] <= wdata_q;
                                pslverr_q  <= 1'b0;
                                prdata_q   <= '0;
                            end else begin
                                prdata_q  <= mem_q[idx];
                                pslverr_q <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    // A setup presented during the completion cycle chains straight into the next access.
                    if (setup) begin
                        addr_q  <= bus.paddr;
                        write_q <= bus.pwrite;
                        wdata_q <= bus.pwdata;
                        cnt_q   <= WAIT_LD;
                        state_q <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_completer_regfile.sv
// Scoreboard bench: the driver queues expected responses, a negedge monitor checks each pready.
// Two extra instances share the driven bus to measure wait-state counts for WAIT_CYCLES 0 and 3.
module tb_apb_completer_regfile;
    logic pclk;
    logic presetn;

    apb_completer_regfile_if #(.AW(8), .DW(8)) bus_m ();
    apb_completer_regfile_if #(.AW(8), .DW(8)) bus_w0 ();
    apb_completer_regfile_if #(.AW(8), .DW(8)) bus_w3 ();

    apb_completer_regfile #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(1))
        dut    (.pclk(pclk), .presetn(presetn), .bus(bus_m));
    apb_completer_regfile #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(0))
        dut_w0 (.pclk(pclk), .presetn(presetn), .bus(bus_w0));
    apb_completer_regfile #(.AW(8), .DW(8), .DEPTH(64), .WAIT_CYCLES(3))
        dut_w3 (.pclk(pclk), .presetn(presetn), .bus(bus_w3));

    assign bus_w0.psel    = bus_m.psel;
    assign bus_w0.penable = bus_m.penable;
    assign bus_w0.pwrite  = bus_m.pwrite;
    assign bus_w0.paddr   = bus_m.paddr;
    assign bus_w0.pwdata  = bus_m.pwdata;
    assign bus_w3.psel    = bus_m.psel;
    assign bus_w3.penable = bus_m.penable;
    assign bus_w3.pwrite  = bus_m.pwrite;
    assign bus_w3.paddr   = bus_m.paddr;
    assign bus_w3.pwdata  = bus_m.pwdata;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        bit         wr;
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per pready and checks the cycle after it returns to zero.
    bit prev_rdy = 1'b0;
    always @(negedge pclk) begin
        exp_t e;
        if (prev_rdy) begin
            check("post_pready", 32'(bus_m.pready), 32'd0);
            check("post_prdata", 32'(bus_m.prdata), 32'd0);
            check("post_pslverr", 32'(bus_m.pslverr), 32'd0);
        end
        if (bus_m.pready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pready", 32'(bus_m.pready), 32'd0);
            end else begin
                e = sb.pop_front();
                check("pslverr", 32'(bus_m.pslverr), 32'(e.err));
                if (!e.wr) check("prdata", 32'(bus_m.prdata), 32'(e.data));
            end
        end
        prev_rdy = (bus_m.pready === 1'b1);
    end

    // Wait-state counters for the sweep instances: pready-low access cycles of the last completion.
    int lo0_cnt = 0, lo0_last = -1;
    int lo3_cnt = 0, lo3_last = -1;
    always @(negedge pclk) begin
        if (!bus_m.psel || !bus_m.penable) lo0_cnt = 0;
        else if (bus_w0.pready) begin lo0_last = lo0_cnt; lo0_cnt = 0; end
        else lo0_cnt++;
        if (!bus_m.psel || !bus_m.penable) lo3_cnt = 0;
        else if (bus_w3.pready) begin lo3_last = lo3_cnt; lo3_cnt = 0; end
        else lo3_cnt++;
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_setup(input bit w, input logic [7:0] a, input logic [7:0] d);
        bus_m.psel    = 1'b1;
        bus_m.penable = 1'b0;
        bus_m.pwrite  = w;
        bus_m.paddr   = a;
        bus_m.pwdata  = d;
        step();
        // Scramble address/data/direction during access; the completer must use the setup values.
        bus_m.penable = 1'b1;
        bus_m.pwrite  = ~w;
        bus_m.paddr   = ~a;
        bus_m.pwdata  = ~d;
    endtask

    task automatic setup_phase(input bit w, input logic [7:0] a, input logic [7:0] d,
                               input bit err, input logic [7:0] ed);
        exp_t e;
        e.wr = w; e.err = err; e.data = ed;
        sb.push_back(e);
        drive_setup(w, a, d);
    endtask

    task automatic wait_ready(output int lo);
        lo = 0;
        while (bus_m.pready !== 1'b1 && lo < 20) begin
            lo++;
            step();
        end
        if (bus_m.pready !== 1'b1) check("ready_timeout", 32'(bus_m.pready), 32'd1);
    endtask

    task automatic idle();
        bus_m.psel    = 1'b0;
        bus_m.penable = 1'b0;
        step();
    endtask

    task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                        input bit err, input logic [7:0] ed);
        int lo;
        setup_phase(w, a, d, err, ed);
        wait_ready(lo);
        check("latency_w1", 32'(lo), 32'd2);
        idle();
    endtask

    initial begin
        int lo;
        bus_m.psel = 1'b0; bus_m.penable = 1'b0; bus_m.pwrite = 1'b0;
        bus_m.paddr = 8'h05; bus_m.pwdata = 8'h00;

        // Reset held two cycles while a setup is presented.
        presetn = 1'b0;
        bus_m.psel = 1'b1;
        step();
        step();
        check("rst_pready", 32'(bus_m.pready), 32'd0);
        check("rst_pslverr", 32'(bus_m.pslverr), 32'd0);
        check("rst_prdata", 32'(bus_m.prdata), 32'd0);
        presetn = 1'b1;
        idle();
        xfer(1'b0, 8'h05, 8'h00, 1'b0, 8'h00);

        // Write then read back.
        xfer(1'b1, 8'h10, 8'hA5, 1'b0, 8'h00);
        xfer(1'b0, 8'h10, 8'h00, 1'b0, 8'hA5);

        // Top valid address.
        xfer(1'b1, 8'h3F, 8'hC3, 1'b0, 8'h00);
        xfer(1'b0, 8'h3F, 8'h00, 1'b0, 8'hC3);

        // Out of range: 0x40 aliases 0x00 in the low bits, so a leaked write would show there.
        xfer(1'b1, 8'h40, 8'h3C, 1'b1, 8'h00);
        xfer(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        xfer(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00);

        // Back-to-back writes, then back-to-back reads.
        setup_phase(1'b1, 8'h00, 8'h11, 1'b0, 8'h00);
        wait_ready(lo);
        check("latency_b2b_a", 32'(lo), 32'd2);
        setup_phase(1'b1, 8'h01, 8'h22, 1'b0, 8'h00);
        wait_ready(lo);
        check("latency_b2b_b", 32'(lo), 32'd2);
        setup_phase(1'b0, 8'h00, 8'h00, 1'b0, 8'h11);
        wait_ready(lo);
        setup_phase(1'b0, 8'h01, 8'h00, 1'b0, 8'h22);
        wait_ready(lo);
        idle();

        // Abort after one access cycle: no response, no write.
        drive_setup(1'b1, 8'h02, 8'h77);
        step();
        idle();
        repeat (3) step();
        xfer(1'b0, 8'h02, 8'h00, 1'b0, 8'h00);

        // Reset during a read's wait cycle: outputs zero, no pready, register file cleared.
        drive_setup(1'b0, 8'h10, 8'h00);
        presetn = 1'b0;
        step();
        check("midrst_pready", 32'(bus_m.pready), 32'd0);
        check("midrst_pslverr", 32'(bus_m.pslverr), 32'd0);
        check("midrst_prdata", 32'(bus_m.prdata), 32'd0);
        presetn = 1'b1;
        idle();
        repeat (4) step();
        xfer(1'b0, 8'h10, 8'h00, 1'b0, 8'h00);

        // Wait-state sweep: hold the access phase long enough for the slowest instance.
        setup_phase(1'b1, 8'h30, 8'h99, 1'b0, 8'h00);
        repeat (7) step();
        idle();
        check("sweep_w0_low", 32'(lo0_last), 32'd1);
        check("sweep_w3_low", 32'(lo3_last), 32'd4);
        xfer(1'b0, 8'h30, 8'h00, 1'b0, 8'h99);

        repeat (3) step();
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
